// File: rtl/conv2d_pkg.sv
// Shared types and helpers for the conv2d frame sequencer and its position counters.
package conv2d_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } conv2d_frame_state_e;

    // Counter width for a range of n positions; at least one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv2d_pos_cnt.sv
// Raster position counter: column wraps at DEPTH_P-1 and steps the row, row wraps at HEIGHT_P-1.
module conv2d_pos_cnt
    import conv2d_pkg::*;
#(
    parameter int DEPTH_P  = 16,
    parameter int HEIGHT_P = 16,
    parameter int COL_W    = cnt_w(DEPTH_P),
    parameter int ROW_W    = cnt_w(HEIGHT_P)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             clear,
    input  logic             en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last_col,
    output logic             last
);

    logic last_row;

    assign last_col = (col == COL_W'(DEPTH_P - 1));
    assign last_row = (row == ROW_W'(HEIGHT_P - 1));
    assign last     = last_col & last_row;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv2d_frame_ctrl.sv
// Frame sequencer around the 3x3 conv2d datapath: gates frames in, masks border results,
// and tags interior results with sof/eol/eof.
module conv2d_frame_ctrl
    import conv2d_pkg::*;
#(
    parameter int WIDTH_P  = 8,
    parameter int DEPTH_P  = 16,
    parameter int HEIGHT_P = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 clear_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH_P-1:0]   data_i,
    output logic                 conv_valid_o,
    input  logic                 conv_ready_i,
    output logic [WIDTH_P-1:0]   conv_data_o,
    input  logic                 res_valid_i,
    output logic                 res_ready_o,
    input  logic [2*WIDTH_P-1:0] res_data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [2*WIDTH_P-1:0] data_o,
    output logic                 sof_o,
    output logic                 eol_o,
    output logic                 eof_o,
    output logic                 busy_o,
    output logic [15:0]          frame_cnt_o
);

    localparam int COL_W = cnt_w(DEPTH_P);
    localparam int ROW_W = cnt_w(HEIGHT_P);

    conv2d_frame_state_e state_q, state_d;

    logic             in_en, in_fire, in_last, in_last_col;
    logic             res_fire, res_last, res_last_col;
    logic             keep, frame_done;
    logic [COL_W-1:0] in_col, res_col;
    logic [ROW_W-1:0] in_row, res_row;
    logic             unused_in_pos;

    // The input position only matters through its last-pixel flag.
    assign unused_in_pos = &{1'b0, in_col, in_row, in_last_col};

    assign in_en        = (state_q != DRAIN);
    assign conv_valid_o = valid_i & in_en;
    assign ready_o      = conv_ready_i & in_en;
    assign conv_data_o  = data_i;
    assign in_fire      = valid_i & ready_o;

    // Results whose window leaves the frame are swallowed here without waiting on downstream.
    assign keep        = (res_row >= ROW_W'(2)) & (res_col >= COL_W'(2));
    assign valid_o     = keep & res_valid_i;
    assign res_ready_o = keep ? ready_i : 1'b1;
    assign data_o      = res_data_i;
    assign res_fire    = res_valid_i & res_ready_o;

    assign sof_o = keep & (res_row == ROW_W'(2)) & (res_col == COL_W'(2));
    assign eol_o = keep & res_last_col;
    assign eof_o = eol_o & (res_row == ROW_W'(HEIGHT_P - 1));

    assign busy_o = (state_q != IDLE);

    conv2d_pos_cnt #(
        .DEPTH_P  (DEPTH_P),
        .HEIGHT_P (HEIGHT_P),
        .COL_W    (COL_W),
        .ROW_W    (ROW_W)
    ) u_in_cnt (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clear    (clear_i),
        .en       (in_fire),
        .col      (in_col),
        .row      (in_row),
        .last_col (in_last_col),
        .last     (in_last)
    );

    conv2d_pos_cnt #(
        .DEPTH_P  (DEPTH_P),
        .HEIGHT_P (HEIGHT_P),
        .COL_W    (COL_W),
        .ROW_W    (ROW_W)
    ) u_res_cnt (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clear    (clear_i),
        .en       (res_fire),
        .col      (res_col),
        .row      (res_row),
        .last_col (res_last_col),
        .last     (res_last)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_fire) state_d = RUN;
                end
                RUN: begin
                    if (in_fire && in_last) begin
                        if (res_fire && res_last) begin
                            state_d    = IDLE;
                            frame_done = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (res_fire && res_last) begin
                        state_d    = IDLE;
                        frame_done = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            frame_cnt_o <= '0;
        end else begin
            state_q <= state_d;
            if (frame_done) frame_cnt_o <= frame_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_conv2d_frame_ctrl.sv
// Self-checking bench for conv2d_frame_ctrl on a 4x4 frame with a queue-based datapath model.
module tb_conv2d_frame_ctrl;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int H  = 4;
    localparam int NP = D * H;

    logic           clk_i = 1'b0;
    logic           rstn_i, clear_i, valid_i, conv_ready_i, res_valid_i, ready_i;
    logic [W-1:0]   data_i;
    logic [2*W-1:0] res_data_i;
    logic           ready_o, conv_valid_o, res_ready_o, valid_o;
    logic           sof_o, eol_o, eof_o, busy_o;
    logic [W-1:0]   conv_data_o;
    logic [2*W-1:0] data_o;
    logic [15:0]    frame_cnt_o;

    conv2d_frame_ctrl #(.WIDTH_P(W), .DEPTH_P(D), .HEIGHT_P(H)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .clear_i      (clear_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .conv_valid_o (conv_valid_o),
        .conv_ready_i (conv_ready_i),
        .conv_data_o  (conv_data_o),
        .res_valid_i  (res_valid_i),
        .res_ready_o  (res_ready_o),
        .res_data_i   (res_data_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .sof_o        (sof_o),
        .eol_o        (eol_o),
        .eof_o        (eof_o),
        .busy_o       (busy_o),
        .frame_cnt_o  (frame_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frame progress as plain pixel/result indices.
    int m_in_idx  = 0;
    int m_res_idx = 0;
    bit m_in_done = 0;
    int m_frames  = 0;
    int cyc       = 0;

    typedef struct { logic [2*W-1:0] data; logic sof, eol, eof; } beat_t;
    typedef struct { logic [W-1:0] px; int due; } pend_t;

    beat_t      beats[$];
    logic [W-1:0] px_q[$];
    logic [W-1:0] px_log[$];
    pend_t      dp_q[$];
    int         start_cyc[$];
    int         end_cyc[$];
    int         joint_cnt;

    // Offers n_px random pixels; the datapath returns {~px, px} lat cycles after acceptance
    // (lat = 0 echoes combinationally in the accepting cycle).
    task automatic run(input int n_px, input int lat, input int rdy_pct, input int crdy_pct);
        int           budget = 0;
        logic         prev_stall = 1'b0;
        logic [2*W-1:0] prev_data = '0;
        logic         in_fire, res_fire, keep;
        int           r, c;
        beats.delete(); px_log.delete(); px_q.delete(); dp_q.delete();
        start_cyc.delete(); end_cyc.delete();
        joint_cnt = 0;
        for (int i = 0; i < n_px; i++) begin
            logic [W-1:0] p;
            p = W'($urandom);
            px_q.push_back(p);
            px_log.push_back(p);
        end
        while ((px_q.size() > 0 || dp_q.size() > 0) && budget < 2000) begin
            valid_i = (px_q.size() > 0);
            data_i  = '0;
            if (valid_i) data_i = px_q[0];
            conv_ready_i = ($urandom_range(99) < crdy_pct);
            ready_i      = ($urandom_range(99) < rdy_pct);
            res_valid_i  = 1'b0;
            res_data_i   = '0;
            if (lat == 0) begin
                res_valid_i = valid_i & conv_ready_i;
                res_data_i  = {~data_i, data_i};
            end else if (dp_q.size() > 0) begin
                if (dp_q[0].due <= cyc) begin
                    res_valid_i = 1'b1;
                    res_data_i  = {~dp_q[0].px, dp_q[0].px};
                end
            end
            #4;
            in_fire  = valid_i & ready_o;
            res_fire = res_valid_i & res_ready_o;
            r    = m_res_idx / D;
            c    = m_res_idx % D;
            keep = (r >= 2) && (c >= 2);
            check("ready_o", ready_o, conv_ready_i & !m_in_done);
            check("conv_valid_o", conv_valid_o, valid_i & !m_in_done);
            check("conv_data_o", conv_data_o, data_i);
            check("valid_o", valid_o, keep & res_valid_i);
            check("res_ready_o", res_ready_o, keep ? ready_i : 1'b1);
            if (valid_o) begin
                check("data_o", data_o, res_data_i);
                check("sof_o", sof_o, (r == 2) && (c == 2));
                check("eol_o", eol_o, c == D - 1);
                check("eof_o", eof_o, (c == D - 1) && (r == H - 1));
            end
            if (prev_stall) begin
                check("stall_valid", valid_o, 1'b1);
                check("stall_data", data_o, prev_data);
            end
            prev_stall = valid_o & !ready_i;
            prev_data  = data_o;
            if (valid_o && ready_i) beats.push_back('{data_o, sof_o, eol_o, eof_o});
            if (in_fire && m_in_idx == 0 && !m_in_done) start_cyc.push_back(cyc);
            if (res_fire && m_res_idx == NP - 1) end_cyc.push_back(cyc);
            if (in_fire && m_in_idx == NP - 1 && res_fire && m_res_idx == NP - 1) joint_cnt++;
            @(posedge clk_i);
            #1;
            if (in_fire) begin
                if (lat > 0) dp_q.push_back('{px_q[0], cyc + lat});
                void'(px_q.pop_front());
                m_in_idx++;
                if (m_in_idx == NP) begin
                    m_in_idx  = 0;
                    m_in_done = 1;
                end
            end
            if (res_fire) begin
                if (lat > 0) void'(dp_q.pop_front());
                m_res_idx++;
                if (m_res_idx == NP) begin
                    m_res_idx = 0;
                    m_in_done = 0;
                    m_frames++;
                end
            end
            check("busy_o", busy_o, (m_in_idx > 0) || m_in_done);
            check("frame_cnt_o", frame_cnt_o, 32'(m_frames[15:0]));
            cyc++;
            budget++;
        end
        check("run_in_budget", budget < 2000, 1'b1);
        valid_i     = 1'b0;
        res_valid_i = 1'b0;
        ready_i     = 1'b1;
        conv_ready_i = 1'b1;
    endtask

    // Beats must be exactly the interior pixels of each frame, in raster order.
    task automatic check_beats(input int frames, input string tag);
        int j = 0;
        int idx;
        check({tag, "_beat_count"}, beats.size(), frames * (H - 2) * (D - 2));
        for (int f = 0; f < frames; f++)
            for (int r = 2; r < H; r++)
                for (int c = 2; c < D; c++) begin
                    if (j < beats.size()) begin
                        idx = f * NP + r * D + c;
                        check({tag, "_beat_data"}, beats[j].data, {~px_log[idx], px_log[idx]});
                        check({tag, "_beat_sof"}, beats[j].sof, (r == 2) && (c == 2));
                        check({tag, "_beat_eol"}, beats[j].eol, c == D - 1);
                        check({tag, "_beat_eof"}, beats[j].eof, (c == D - 1) && (r == H - 1));
                    end
                    j++;
                end
    endtask

    typedef struct {
        logic v, cr, rv, rdy;
        logic [W-1:0] d;
        logic e_ready, e_cvalid, e_valid, e_rready;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1};

        rstn_i = 1'b0; clear_i = 1'b0; valid_i = 1'b0; conv_ready_i = 1'b0;
        res_valid_i = 1'b0; ready_i = 1'b0; data_i = '0; res_data_i = '0;

        // Combinational behaviour while held in reset (IDLE, all positions zero).
        for (int i = 0; i < 5; i++) begin
            valid_i = vecs[i].v; conv_ready_i = vecs[i].cr;
            res_valid_i = vecs[i].rv; ready_i = vecs[i].rdy; data_i = vecs[i].d;
            res_data_i = {vecs[i].d, ~vecs[i].d};
            #1;
            check("rst_ready_o", ready_o, vecs[i].e_ready);
            check("rst_conv_valid_o", conv_valid_o, vecs[i].e_cvalid);
            check("rst_conv_data_o", conv_data_o, vecs[i].d);
            check("rst_valid_o", valid_o, vecs[i].e_valid);
            check("rst_res_ready_o", res_ready_o, vecs[i].e_rready);
        end
        check("rst_busy_o", busy_o, 1'b0);
        check("rst_frame_cnt_o", frame_cnt_o, 16'd0);
        valid_i = 1'b0; res_valid_i = 1'b0; ready_i = 1'b1; conv_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Basic frame, full downstream throughput.
        run(NP, 1, 100, 100);
        check_beats(1, "basic");
        check("basic_frames", frame_cnt_o, 16'd1);
        check("basic_idle", busy_o, 1'b0);

        // Downstream ready toggling at 50%.
        run(NP, 1, 50, 100);
        check_beats(1, "stall");

        // Two frames back to back with a slow datapath: no overlap.
        run(2 * NP, 5, 100, 100);
        check_beats(2, "drain");
        check("drain_edges", (start_cyc.size() == 2) && (end_cyc.size() == 2), 1'b1);
        if (start_cyc.size() == 2 && end_cyc.size() == 2)
            check("frame2_start_gap", start_cyc[1] - end_cyc[0], 1);

        // Random stalls on both sides.
        run(NP, 2, 70, 60);
        check_beats(1, "random");

        // Abort a partial frame, then run a complete one.
        f0 = m_frames;
        run(7, 1, 100, 100);
        check("partial_beats", beats.size(), 0);
        check("partial_busy", busy_o, 1'b1);
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        m_in_idx = 0; m_res_idx = 0; m_in_done = 0;
        check("clear_busy", busy_o, 1'b0);
        check("clear_frame_cnt", frame_cnt_o, 32'(f0));
        run(NP, 1, 100, 100);
        check_beats(1, "after_clear");
        check("after_clear_frames", frame_cnt_o, 32'(f0 + 1));

        // Zero-latency datapath: last pixel and last result share a cycle.
        f0 = m_frames;
        run(NP, 0, 100, 100);
        check_beats(1, "joint");
        check("joint_once", joint_cnt, 1);
        check("joint_frames", frame_cnt_o, 32'(f0 + 1));
        check("joint_idle", busy_o, 1'b0);

        // Reset in the middle of a frame drops all position state at once.
        run(5, 1, 100, 100);
        rstn_i = 1'b0;
        #1;
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_frame_cnt", frame_cnt_o, 16'd0);
        m_in_idx = 0; m_res_idx = 0; m_in_done = 0; m_frames = 0;
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        run(NP, 1, 100, 100);
        check_beats(1, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/conv2d_frame_ctrl.md
# conv2d_frame_ctrl

Frame sequencer placed around the 3x3 conv2d datapath (line buffer plus window). It gates whole frames into the datapath and tracks the raster position of every pixel it accepts and every result it receives. Results whose 3x3 window is not fully inside the current frame are dropped. Only the (HEIGHT_P-2)x(DEPTH_P-2) interior results go downstream, tagged with sof/eol/eof markers.

## Interface
- WIDTH_P, 8, pixel width
- DEPTH_P, 16, pixels per row; must match the datapath line depth; ≥3
- HEIGHT_P, 16, rows per frame; ≥3
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous abort: counters and FSM to IDLE
- valid_i  in  1  upstream pixel valid
- ready_o  out  1  upstream ready
- data_i  in  WIDTH_P  upstream pixel
- conv_valid_o  out  1  pixel valid to datapath
- conv_ready_i  in  1  datapath ready
- conv_data_o  out  WIDTH_P  pixel to datapath
- res_valid_i  in  1  datapath result valid
- res_ready_o  out  1  datapath result ready
- res_data_i  in  2*WIDTH_P  datapath result
- valid_o  out  1  interior result valid
- ready_i  in  1  downstream ready
- data_o  out  2*WIDTH_P  interior result
- sof_o / eol_o / eof_o  out  1 each  first interior pixel / last of row / last of frame
- busy_o  out  1  FSM not IDLE
- frame_cnt_o  out  16  completed frames, wraps at 2^16

## Operation
- Input path is combinational pass-through: conv_valid_o = valid_i & in_en; ready_o = conv_ready_i & in_en; conv_data_o = data_i.
- in_en = 1 in IDLE and RUN, 0 in DRAIN.
- Input position (in_col, in_row) advances on valid_i & ready_o. Raster order; col wraps at DEPTH_P-1 and increments row.
- Result position (res_col, res_row) advances on res_valid_i & res_ready_o. One result per accepted pixel. The result at (r,c) is the window centred on (r-1,c-1).
- keep = (res_row ≥ 2) & (res_col ≥ 2).
- keep=1: valid_o = res_valid_i, res_ready_o = ready_i, data_o = res_data_i.
- keep=0: valid_o = 0, res_ready_o = 1. The result is consumed and discarded.
- sof_o = keep & res_row==2 & res_col==2.
- eol_o = keep & res_col==DEPTH_P-1.
- eof_o = eol_o & res_row==HEIGHT_P-1.
- Markers are qualified by valid_o.
- FSM, held in the package enum:
  - IDLE→RUN on the first accepted input pixel.
  - RUN→DRAIN when pixel (HEIGHT_P-1, DEPTH_P-1) is accepted; in counters wrap to 0.
  - DRAIN→IDLE when the result at (HEIGHT_P-1, DEPTH_P-1) is handshaken. Result counters wrap to 0 and frame_cnt_o increments.
  - If the last input pixel and the last result complete in the same cycle, the FSM goes RUN→IDLE and frame_cnt_o increments.
- clear_i has priority over all transitions. It zeroes the position counters and state; frame_cnt_o is kept. Datapath residue is absorbed by the keep mask of the next frame.

## Timing
- Reset (async assert, sync release): state IDLE, all counters 0, frame_cnt_o 0, busy_o 0.
  - valid_o = 0 during reset, since res_valid_i must be 0 from a reset datapath.
  - conv_valid_o follows valid_i. ready_o follows conv_ready_i (in_en=1 in IDLE).
- Latency through this block: 0 cycles on both paths. All outputs except the counters are combinational from the current state.
- A valid/ready pair that is stalled must hold; this block does not alter data under stall.
- busy_o and frame_cnt_o are registered and update the cycle after the triggering handshake.
- In DRAIN, ready_o = 0, so the next frame waits until the last result is out. There is no frame overlap.
- Reset mid-frame discards all position state immediately.

## Structure
- Shared package conv2d_pkg holds:
  - state enum conv2d_frame_state_e {IDLE, RUN, DRAIN};
  - localparam helpers COL_W = $clog2(DEPTH_P), ROW_W = $clog2(HEIGHT_P), passed as parameters.
- One sub-module, conv2d_pos_cnt: raster column/row counter with en, clear, last flag. Parameterised on DEPTH_P/HEIGHT_P. Instantiated twice, for the input position and the result position.

## Test plan
- Reset with valid_i=1 and conv_ready_i=1 → ready_o=1, valid_o=0, busy_o=0, frame_cnt_o=0.
- DEPTH_P=4, HEIGHT_P=4: feed 16 pixels, datapath model echoes each pixel as its result → exactly 4 valid_o beats, carrying results of input indices 10, 11, 14, 15.
  - sof_o on the first beat.
  - eol_o on the 2nd and 4th beats.
  - eof_o on the 4th beat.
  - frame_cnt_o=1 and busy_o=0 afterwards.
- Same frame with ready_i toggling 50% → 4 beats, data_o stable under stall; dropped results still consumed at one per cycle.
- Second frame offered while the model delays results by 5 cycles → ready_o=0 for the whole DRAIN window; frame 2 starts the cycle after the last result handshake.
- clear_i pulse after 7 pixels, then a full 16-pixel frame → only 4 interior beats from the new frame.
- Last input handshake and last result handshake in the same cycle → direct RUN→IDLE, frame_cnt_o increments once.
